// File: rtl/timer_ctrl_pkg.sv
// Shared definitions for the timer controller: register map, CTRL/STATUS bit
// positions and the controller FSM encoding.
package timer_ctrl_pkg;

  localparam logic [1:0] ADDR_CTRL   = 2'd0;
  localparam logic [1:0] ADDR_RELOAD = 2'd1;
  localparam logic [1:0] ADDR_COUNT  = 2'd2;
  localparam logic [1:0] ADDR_STATUS = 2'd3;

  localparam int CTRL_EN   = 0;
  localparam int CTRL_DIR  = 1;
  localparam int CTRL_MODE = 2;
  localparam int CTRL_IE   = 3;

  localparam int STAT_TC      = 0;
  localparam int STAT_RUNNING = 1;

  typedef enum logic [1:0] {
    ST_IDLE = 2'd0,
    ST_ARM  = 2'd1,
    ST_RUN  = 2'd2,
    ST_DONE = 2'd3
  } state_e;

endpackage

// File: rtl/timer_ctrl_cnt32.sv
// 32-bit loadable up/down counter with a terminal-count flag for the current
// direction (all ones when counting up, zero when counting down).
module timer_cnt32
  import timer_ctrl_pkg::*;
(
  input  logic        clk,
  input  logic        rst_n,
  input  logic        load,
  input  logic [31:0] load_val,
  input  logic        step,
  input  logic        up,
  output logic [31:0] cnt,
  output logic        terminal
);

  logic [31:0] cnt_d, cnt_q;

  always_comb begin
    cnt_d = cnt_q;
    if (load) begin
      cnt_d = load_val;
    end else if (step) begin
      cnt_d = up ? cnt_q + 32'd1 : cnt_q - 32'd1;
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      cnt_q <= '0;
    end else begin
      cnt_q <= cnt_d;
    end
  end

  assign cnt      = cnt_q;
  assign terminal = up ? (cnt_q == 32'hFFFF_FFFF) : (cnt_q == 32'd0);

endmodule

// File: rtl/timer_ctrl.sv
// Programmable timer: register file, arm/run/done FSM and tick prescaler
// driving a 32-bit reversible counter, with a level interrupt on terminal count.
module timer_ctrl
  import timer_ctrl_pkg::*;
#(
  parameter int DIV   = 1,
  parameter int PRE_W = 16
) (
  input  logic        clk,
  input  logic        rst_n,
  input  logic        we,
  input  logic [1:0]  addr,
  input  logic [31:0] wdata,
  output logic [31:0] rdata,
  output logic [31:0] cnt_out,
  output logic        tc_pulse,
  output logic        irq
);

  localparam logic [PRE_W-1:0] PRE_LAST = PRE_W'(DIV - 1);

  state_e           state_d, state_q;
  logic             en_d, en_q, dir_d, dir_q, mode_d, mode_q, ie_d, ie_q;
  logic             tc_d, tc_q, tc_pulse_d, tc_pulse_q;
  logic [31:0]      reload_d, reload_q;
  logic [PRE_W-1:0] pre_d, pre_q;

  logic        wr_ctrl, wr_reload, wr_count, wr_status;
  logic        stop_req, tick, term_evt;
  logic        cnt_load, cnt_step, cnt_term;
  logic [31:0] cnt_load_val, cnt_val;

  assign wr_ctrl   = we && (addr == ADDR_CTRL);
  assign wr_reload = we && (addr == ADDR_RELOAD);
  assign wr_count  = we && (addr == ADDR_COUNT);
  assign wr_status = we && (addr == ADDR_STATUS);

  // Clearing EN in RUN suppresses the tick of that cycle; a COUNT write on a
  // tick cycle wins over both the step and terminal detection.
  assign stop_req = wr_ctrl && !wdata[CTRL_EN];
  assign tick     = (state_q == ST_RUN) && !stop_req && (pre_q == PRE_LAST);
  assign term_evt = tick && !wr_count && cnt_term;

  always_comb begin
    state_d      = state_q;
    pre_d        = pre_q;
    cnt_load     = 1'b0;
    cnt_load_val = wdata;
    cnt_step     = 1'b0;
    {ie_d, mode_d, dir_d, en_d} = {ie_q, mode_q, dir_q, en_q};
    if (wr_ctrl) begin
      {ie_d, mode_d, dir_d, en_d} = wdata[3:0];
    end
    reload_d = wr_reload ? wdata : reload_q;

    case (state_q)
      ST_IDLE, ST_DONE: begin
        if (wr_ctrl) begin
          state_d = wdata[CTRL_EN] ? ST_ARM : ST_IDLE;
        end
      end
      ST_ARM: begin
        state_d      = stop_req ? ST_IDLE : ST_RUN;
        pre_d        = '0;
        cnt_load     = 1'b1;
        cnt_load_val = reload_q;
      end
      ST_RUN: begin
        if (stop_req) begin
          state_d = ST_IDLE;
        end else begin
          pre_d = (pre_q == PRE_LAST) ? '0 : pre_q + PRE_W'(1);
          if (term_evt) begin
            if (mode_q) begin
              cnt_load     = 1'b1;
              cnt_load_val = reload_q;
            end else begin
              en_d    = 1'b0;
              state_d = ST_DONE;
            end
          end else if (tick && !wr_count) begin
            cnt_step = 1'b1;
          end
        end
      end
      default: state_d = ST_IDLE;
    endcase

    if (wr_count) begin
      cnt_load     = 1'b1;
      cnt_load_val = wdata;
    end

    tc_d = tc_q;
    if (wr_status && wdata[STAT_TC]) begin
      tc_d = 1'b0;
    end
    if (term_evt) begin
      tc_d = 1'b1;
    end
    tc_pulse_d = term_evt;
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q    <= ST_IDLE;
      en_q       <= 1'b0;
      dir_q      <= 1'b0;
      mode_q     <= 1'b0;
      ie_q       <= 1'b0;
      tc_q       <= 1'b0;
      tc_pulse_q <= 1'b0;
      reload_q   <= '0;
      pre_q      <= '0;
    end else begin
      state_q    <= state_d;
      en_q       <= en_d;
      dir_q      <= dir_d;
      mode_q     <= mode_d;
      ie_q       <= ie_d;
      tc_q       <= tc_d;
      tc_pulse_q <= tc_pulse_d;
      reload_q   <= reload_d;
      pre_q      <= pre_d;
    end
  end

  timer_cnt32 u_cnt (
    .clk      (clk),
    .rst_n    (rst_n),
    .load     (cnt_load),
    .load_val (cnt_load_val),
    .step     (cnt_step),
    .up       (dir_q),
    .cnt      (cnt_val),
    .terminal (cnt_term)
  );

  always_comb begin
    rdata = '0;
    case (addr)
      ADDR_CTRL:   rdata = {28'd0, ie_q, mode_q, dir_q, en_q};
      ADDR_RELOAD: rdata = reload_q;
      ADDR_COUNT:  rdata = cnt_val;
      ADDR_STATUS: rdata = {30'd0, state_q == ST_RUN, tc_q};
      default:     rdata = '0;
    endcase
  end

  assign cnt_out  = cnt_val;
  assign tc_pulse = tc_pulse_q;
  assign irq      = tc_q && ie_q;

endmodule
